// File: rtl/text_console_ctrl.sv
// Write-side controller for the screen character RAM: byte stream in, cursor tracking, clear.
// Optional backspace handling is enabled by defining TEXT_CONSOLE_BACKSPACE_EN.
`timescale 1ns/1ps
module text_console_ctrl #(
   parameter int unsigned COLS      = 80,
   parameter int unsigned ROWS      = 25,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [10:0] write_character_pos,
   output logic [7:0]  write_character,
   output logic        write_strobe,
   output logic [10:0] cursor_pos,
   output logic        busy
);

   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CW-1:0] LastCol  = CW'(COLS - 1);
   localparam logic [RW-1:0] LastRow  = RW'(ROWS - 1);
   localparam logic [10:0]   LastCell = 11'(COLS * ROWS - 1);
   localparam logic [10:0]   ColsW    = 11'(COLS);

   typedef enum logic [0:0] {StClear, StIdle} state_e;

   state_e        state_q, state_d;
   logic [10:0]   clr_q, clr_d;
   logic [10:0]   cur_q, cur_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [10:0]   wpos_q, wpos_d;
   logic [7:0]    wchar_q, wchar_d;
   logic          wstb_q, wstb_d;
   logic          rdy_q, rdy_d;
   logic          busy_q, busy_d;
   logic          accept;

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      cur_d   = cur_q;
      col_d   = col_q;
      row_d   = row_q;
      wpos_d  = wpos_q;
      wchar_d = wchar_q;
      wstb_d  = 1'b0;
      accept  = 1'b0;

      unique case (state_q)
         StClear: begin
            wstb_d  = 1'b1;
            wpos_d  = clr_q;
            wchar_d = FILL_CHAR;
            if (clr_q == LastCell) begin
               state_d = StIdle;
               clr_d   = '0;
            end else begin
               clr_d = clr_q + 11'(1);
            end
         end
         StIdle: begin
            accept = in_valid && rdy_q;
            if (accept) begin
               if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                  wstb_d  = 1'b1;
                  wpos_d  = cur_q;
                  wchar_d = in_data;
                  if (col_q == LastCol) begin
                     col_d = '0;
                     // No scrolling: the last cell wraps to the top-left corner
                     if (row_q == LastRow) begin
                        row_d = '0;
                        cur_d = '0;
                     end else begin
                        row_d = row_q + RW'(1);
                        cur_d = cur_q + 11'(1);
                     end
                  end else begin
                     col_d = col_q + CW'(1);
                     cur_d = cur_q + 11'(1);
                  end
               end else begin
                  case (in_data)
                     8'h0A: begin
                        col_d = '0;
                        if (row_q == LastRow) begin
                           row_d = '0;
                           cur_d = '0;
                        end else begin
                           row_d = row_q + RW'(1);
                           cur_d = cur_q + ColsW - 11'(col_q);
                        end
                     end
                     8'h0D: begin
                        col_d = '0;
                        cur_d = cur_q - 11'(col_q);
                     end
                     8'h0C: begin
                        cur_d   = '0;
                        col_d   = '0;
                        row_d   = '0;
                        clr_d   = '0;
                        state_d = StClear;
                     end
`ifdef TEXT_CONSOLE_BACKSPACE_EN
                     8'h08: begin
                        if (col_q != '0) begin
                           col_d   = col_q - CW'(1);
                           cur_d   = cur_q - 11'(1);
                           wstb_d  = 1'b1;
                           wpos_d  = cur_q - 11'(1);
                           wchar_d = FILL_CHAR;
                        end
                     end
`endif
                     default: ;
                  endcase
               end
            end
         end
         default: state_d = StClear;
      endcase

      // Ready only after a full cycle in IDLE, so it rises the cycle after the last clear strobe
      rdy_d  = (state_q == StIdle) && (state_d == StIdle);
      busy_d = !rdy_d;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StClear;
         clr_q   <= '0;
         cur_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         wpos_q  <= '0;
         wchar_q <= '0;
         wstb_q  <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
         cur_q   <= cur_d;
         col_q   <= col_d;
         row_q   <= row_d;
         wpos_q  <= wpos_d;
         wchar_q <= wchar_d;
         wstb_q  <= wstb_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   assign in_ready            = rdy_q;
   assign busy                = busy_q;
   assign write_strobe        = wstb_q;
   assign write_character_pos = wpos_q;
   assign write_character     = wchar_q;
   assign cursor_pos          = cur_q;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl (80x25); expected RAM writes go through a scoreboard queue.
`timescale 1ns/1ps
module tb_text_console_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [10:0] write_character_pos;
   logic [7:0]  write_character;
   logic        write_strobe;
   logic [10:0] cursor_pos;
   logic        busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [18:0] exp_q[$];
   logic [18:0] mon_e;

   always #5 CLK = ~CLK;

   text_console_ctrl dut (
      .CLK                 (CLK),
      .RST_N               (RST_N),
      .in_data             (in_data),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .write_character_pos (write_character_pos),
      .write_character     (write_character),
      .write_strobe        (write_strobe),
      .cursor_pos          (cursor_pos),
      .busy                (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Every strobe must match the oldest expected write
   always @(negedge CLK) begin
      if (write_strobe === 1'b1) begin
         check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("wr_pos", 32'(write_character_pos), 32'(mon_e[18:8]));
            check("wr_char", 32'(write_character), 32'(mon_e[7:0]));
         end
      end
   end

   task automatic push(input int pos, input logic [7:0] ch);
      exp_q.push_back({11'(pos), ch});
   endtask

   task automatic send(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic put(input int pos, input logic [7:0] b);
      push(pos, b);
      send(b);
   endtask

   task automatic settle(input string tag, input int cur);
      @(negedge CLK);
      #1;
      check(tag, 32'(cursor_pos), 32'(cur));
      check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_stb"}, 32'(write_strobe), 32'd0);
      check({tag, "_pos"}, 32'(write_character_pos), 32'd0);
      check({tag, "_chr"}, 32'(write_character), 32'd0);
      check({tag, "_rdy"}, 32'(in_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_cur"}, 32'(cursor_pos), 32'd0);
   endtask

   task automatic run_clear(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 2000; i++) push(i, 8'h20);
      for (int c = 0; c < 8 && !found; c++) begin
         @(negedge CLK);
         if (write_strobe === 1'b1) found = 1'b1;
      end
      check({tag, "_start"}, 32'(found), 32'd1);
      for (int i = 1; i < 2000; i++) begin
         @(negedge CLK);
         check({tag, "_consec"}, 32'(write_strobe), 32'd1);
      end
      check({tag, "_rdy_last"}, 32'(in_ready), 32'd0);
      @(negedge CLK);
      #1;
      check({tag, "_done_stb"}, 32'(write_strobe), 32'd0);
      check({tag, "_done_rdy"}, 32'(in_ready), 32'd1);
      check({tag, "_done_busy"}, 32'(busy), 32'd0);
      check({tag, "_done_cur"}, 32'(cursor_pos), 32'd0);
      check({tag, "_done_q"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      RST_N = 1'b1;
      #1 RST_N = 1'b0;
      #1 check_reset("rst");
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      run_clear("clr0");

      // Back-to-back bytes with valid held
      put(0, 8'h41);
      put(1, 8'h42);
      settle("ab_cur", 2);

      // Row wrap, then last-cell wrap
      for (int i = 2; i < 80; i++) put(i, 8'h61 + 8'(i % 26));
      put(80, 8'h5A);
      settle("rowwrap_cur", 81);
      for (int i = 0; i < 23; i++) send(8'h0A);
      settle("lf23_cur", 1920);
      for (int i = 1920; i < 1999; i++) put(i, 8'h30 + 8'(i % 10));
      put(1999, 8'h51);
      settle("lastcell_cur", 0);

      // LF / CR
      for (int i = 0; i < 5; i++) put(i, 8'h78);
      settle("five_cur", 5);
      send(8'h0A);
      settle("lf_cur", 80);
      put(80, 8'h61);
      put(81, 8'h62);
      settle("ab2_cur", 82);
      send(8'h0D);
      settle("cr_cur", 80);
      for (int i = 0; i < 23; i++) send(8'h0A);
      settle("lf_row24_cur", 1920);
      send(8'h0A);
      settle("lf_wrap_cur", 0);

      // Dropped bytes and BS at column 0
      send(8'h01);
      send(8'h7F);
      send(8'h08);
      settle("drop_cur", 0);

      // Backspace at column 3
      put(0, 8'h61);
      put(1, 8'h62);
      put(2, 8'h63);
      settle("abc_cur", 3);
`ifdef TEXT_CONSOLE_BACKSPACE_EN
      push(2, 8'h20);
      send(8'h08);
      settle("bs_cur", 2);
`else
      send(8'h08);
      settle("bs_cur", 3);
`endif

      // Form feed at cursor 123, reset mid-clear
      send(8'h0A);
      settle("ff_pre_lf", 80);
      for (int i = 80; i < 123; i++) put(i, 8'h6D);
      settle("ff_pre_cur", 123);
      send(8'h0C);
      @(negedge CLK);
      #1;
      check("ff_gap_stb", 32'(write_strobe), 32'd0);
      check("ff_cur", 32'(cursor_pos), 32'd0);
      check("ff_rdy", 32'(in_ready), 32'd0);
      check("ff_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 2000; i++) push(i, 8'h20);
      found = 1'b0;
      for (int c = 0; c < 600 && !found; c++) begin
         @(negedge CLK);
         if (write_strobe === 1'b1 && write_character_pos === 11'd499) found = 1'b1;
      end
      check("ff_clear_499", 32'(found), 32'd1);
      RST_N = 1'b0;
      #1 check_reset("midrst");
      exp_q.delete();
      @(negedge CLK);
      RST_N = 1'b1;
      run_clear("clr1");

      put(0, 8'h4B);
      settle("post_clr_cur", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Write-side controller for the 2048-entry screen character RAM. It accepts a byte stream (CPU/UART) over a valid/ready handshake, tracks a text cursor, and interprets a small set of control codes. It issues one RAM write per cycle on the RAM write port; the read port remains owned by the VGA scan-out. On reset and on form-feed it sequences a full-screen clear.

## Interface
- `COLS`, default 80: characters per row.
- `ROWS`, default 25: rows per screen. `COLS*ROWS` must be ≤ 2048.
- `FILL_CHAR`, default 8'h20: byte written by clear and by backspace.
- `CLK` input, 1 bit: single clock; all logic on its rising edge.
- `RST_N` input, 1 bit: reset, asynchronous and active-low.
- `in_data` input, 8 bits: incoming byte.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: the controller can accept a byte this cycle.
- `write_character_pos` output, 11 bits: RAM write address.
- `write_character` output, 8 bits: RAM write data.
- `write_strobe` output, 1 bit: RAM write enable, one cycle per write.
- `cursor_pos` output, 11 bits: linear cursor position, row*COLS+col.
- `busy` output, 1 bit: a clear is in progress.

## Operation
- State machine with two states:
  - CLEAR: `in_ready`=0 and `busy`=1. Each cycle writes `FILL_CHAR` to clear counter `clr`, starting at 0. After writing `COLS*ROWS-1`, the next state is IDLE.
  - IDLE: `in_ready`=1 and `busy`=0. A byte is accepted when `in_valid && in_ready`.
- Internal state: `cursor_pos` (11 bits), `col` (0..COLS-1) and `row` (0..ROWS-1). No multiplier is used; `cursor_pos` is updated incrementally.
- Handling of an accepted byte `b`:
  - 0x20–0x7E: write `b` at `cursor_pos`, then advance the cursor.
    - Normal advance: `col`+1 and `cursor_pos`+1.
    - At `col`=COLS-1: `col`=0 and `row`+1.
    - At the last cell (`row`=ROWS-1, `col`=COLS-1): the cursor wraps to position 0 (row 0, col 0). There is no scrolling.
  - 0x0A (LF, newline): `cursor_pos` += COLS-`col`, `col`=0, `row`+1. If `row` was ROWS-1, the cursor wraps to position 0. No write.
  - 0x0D (CR): `cursor_pos` -= `col`, `col`=0. No write.
  - 0x0C (FF): cursor set to 0; next state is CLEAR with `clr`=0. No write in the accept cycle.
  - 0x08 (BS): handling depends on the macro; see Configuration.
  - Any other byte is consumed and dropped, with no write and no cursor change.
- Reset-state values: state=CLEAR, `clr`=0, cursor/`col`/`row`=0, `write_strobe`=0, `write_character_pos`=0, `write_character`=0, `in_ready`=0, `busy`=1.
  - The first clear write occurs on the first clock edge after `RST_N` deasserts.
- `RST_N` asserted mid-clear or mid-stream: all state returns to the reset values immediately. The clear then restarts from 0.

## Timing
- All outputs are registered.
- Acceptance on edge N produces `write_strobe`=1 with the position and data during cycle N+1.
- `cursor_pos` shows the post-advance value in that same cycle N+1.
- Throughput: one byte per cycle in IDLE, with `in_ready` held at 1.
- A clear takes exactly `COLS*ROWS` strobe cycles at consecutive addresses.
  - `in_ready` rises in the cycle after the last clear strobe.
  - FF acceptance leaves one cycle without a strobe before the first clear write.
- `write_strobe` is 0 in every cycle that has no write. Position and data hold their last values.

## Configuration
- `TEXT_CONSOLE_BACKSPACE_EN` defined:
  - 0x08 with `col`>0: `col`-1 and `cursor_pos`-1, then write `FILL_CHAR` at the new position (same N+1 timing).
  - 0x08 with `col`=0: no-op, with no wrap to the previous row.
- Undefined: 0x08 is dropped like any other non-printable byte.

## Test plan
- Reset release, defaults 80x25: 2000 strobes of 0x20 at positions 0..1999 on consecutive cycles, then `in_ready`=1 and `busy`=0; cursor=0.
- Back-to-back 'A' and 'B' with `in_valid` held: strobes (0,0x41) then (1,0x42) on consecutive cycles; `cursor_pos`=2.
- 80 printables, then 'Z': 'Z' is written at 80 (row 1, col 0). Then a byte at position 1999: cursor wraps to 0.
- From cursor 5: LF gives 80 with no strobe. Then "ab", CR: cursor 80. LF at row 24: cursor 0.
- FF at cursor 123, then `RST_N` pulsed low at clear count 500: outputs return to reset values asynchronously; the clear restarts at 0 and completes with 2000 strobes.
- BS, macro defined: at cursor 3 (col 3) gives strobe (2,0x20) and cursor 2. At col 0, no strobe and no change. Macro undefined: BS gives no strobe and the cursor is unchanged.
